// File: rtl/ram_fib_engine_pkg.sv
// Shared definitions for the RAM-backed sequence engine: FSM state encoding
// and the arithmetic mode constants.
package ram_fib_engine_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT0 = 3'd1,
      ST_INIT1 = 3'd2,
      ST_RD_A  = 3'd3,
      ST_RD_B  = 3'd4,
      ST_WR    = 3'd5,
      ST_DONE  = 3'd6
   } fib_state_t;

   // mode input encoding
   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/ram_fib_engine_ram_dp.sv
// Dual-port RAM: port A synchronous read/write (engine), port B synchronous
// read-only (host). Both ports return old data on a same-cycle read/write of
// one address. The array has no reset; only the host read register does.
module ram_dp #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic [DATA_W-1:0] a_rdata,
   input  logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Engine port: write when enabled, always read (read-before-write).
   always_ff @(posedge clk) begin
      if (a_we) begin
         mem[a_addr] <= a_wdata;
      end
      a_rdata <= mem[a_addr];
   end

   // Host port: registered read, cleared by reset so rd_data starts at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_rdata <= '0;
      end else begin
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/ram_fib_engine.sv
// Sequence engine: seeds addresses 0 and 1, then fills addresses 2..len-1
// with mem[i-1] + mem[i-2] (or mem[i-1] - mem[i-2]) using a single RAM port
// in a three-cycle read/read/write loop. A host port reads the RAM freely.
//
// Control protocol: start is a one-cycle request honoured only in IDLE (no
// queuing, no back-pressure); busy is high from the cycle after acceptance
// until the engine enters DONE; done is a one-cycle completion pulse.
module ram_fib_engine
   import ram_fib_engine_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              mode,
   input  logic [DATA_W-1:0] seed0,
   input  logic [DATA_W-1:0] seed1,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output fib_state_t        dbg_state
);

   localparam logic [ADDR_W:0] LEN_MIN = (ADDR_W + 1)'(2);
   localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

   fib_state_t          state;
   logic                mode_q;
   logic [DATA_W-1:0]   seed0_q;
   logic [DATA_W-1:0]   seed1_q;
   logic [ADDR_W:0]     len_q;
   logic [ADDR_W:0]     i_q;
   logic [DATA_W-1:0]   op_a;

   logic [ADDR_W:0]     len_clamped;
   logic [ADDR_W:0]     i_m1;
   logic [ADDR_W:0]     i_m2;
   logic [ADDR_W:0]     i_next;
   logic [DATA_W:0]     sum_w;
   logic [DATA_W:0]     diff_w;
   logic [DATA_W:0]     result;

   logic                a_we;
   logic [ADDR_W-1:0]   a_addr;
   logic [DATA_W-1:0]   a_wdata;
   logic [DATA_W-1:0]   a_rdata;

   assign dbg_state = state;

   // Clamp the requested length into [2, DEPTH].
   always_comb begin
      len_clamped = len;
      if (len < LEN_MIN) begin
         len_clamped = LEN_MIN;
      end else if (len > LEN_MAX) begin
         len_clamped = LEN_MAX;
      end
   end

   // Index arithmetic and the add/subtract datapath; bit DATA_W of each
   // widened result is the carry (add) or borrow (subtract).
   always_comb begin
      i_m1   = i_q - (ADDR_W + 1)'(1);
      i_m2   = i_q - (ADDR_W + 1)'(2);
      i_next = i_q + (ADDR_W + 1)'(1);
      sum_w  = {1'b0, a_rdata} + {1'b0, op_a};
      diff_w = {1'b0, a_rdata} - {1'b0, op_a};
      result = (mode_q == MODE_SUB) ? diff_w : sum_w;
   end

   // Engine RAM port decode from the current state.
   always_comb begin
      a_we    = 1'b0;
      a_addr  = '0;
      a_wdata = '0;
      case (state)
         ST_INIT0: begin
            a_we    = 1'b1;
            a_addr  = '0;
            a_wdata = seed0_q;
         end
         ST_INIT1: begin
            a_we    = 1'b1;
            a_addr  = ADDR_W'(1);
            a_wdata = seed1_q;
         end
         ST_RD_A: a_addr = i_m2[ADDR_W-1:0];
         ST_RD_B: a_addr = i_m1[ADDR_W-1:0];
         ST_WR: begin
            a_we    = 1'b1;
            a_addr  = i_q[ADDR_W-1:0];
            a_wdata = result[DATA_W-1:0];
         end
         default: begin
            a_we    = 1'b0;
            a_addr  = '0;
            a_wdata = '0;
         end
      endcase
   end

   // Sequencer FSM with registered busy/done/ovf.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
         i_q     <= '0;
         mode_q  <= MODE_ADD;
         seed0_q <= '0;
         seed1_q <= '0;
         len_q   <= LEN_MIN;
         op_a    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_INIT0;
                  busy    <= 1'b1;
                  mode_q  <= mode;
                  seed0_q <= seed0;
                  seed1_q <= seed1;
                  len_q   <= len_clamped;
                  ovf     <= 1'b0;
                  i_q     <= (ADDR_W + 1)'(2);
               end
            end
            ST_INIT0: state <= ST_INIT1;
            ST_INIT1: begin
               if (len_q > LEN_MIN) begin
                  state <= ST_RD_A;
               end else begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_RD_A: state <= ST_RD_B;
            ST_RD_B: begin
               op_a  <= a_rdata;
               state <= ST_WR;
            end
            ST_WR: begin
               ovf <= ovf | result[DATA_W];
               i_q <= i_next;
               if (i_next < len_q) begin
                  state <= ST_RD_A;
               end else begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   ram_dp #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
   ) u_ram (
      .clk    (clk),
      .rst_n  (rst_n),
      .a_we   (a_we),
      .a_addr (a_addr),
      .a_wdata(a_wdata),
      .a_rdata(a_rdata),
      .b_addr (rd_addr),
      .b_rdata(rd_data)
   );

endmodule
